// File: rtl/pulse_stretcher.sv
// Stretches single-cycle requests into HIGH_CYCLES-wide pulses.
// Consecutive pulses are separated by GAP_CYCLES low cycles.
// Requests that arrive while a pulse is running are queued.
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous, active-low reset
//   src      - request; each high sample is one request
//   out      - registered stretched level
//   busy     - pulse/gap running or requests queued
//   pending  - queued requests not yet started
//   overflow - one-cycle flag when a request is dropped
module pulse_stretcher #(
  parameter int HIGH_CYCLES = 8,
  parameter int GAP_CYCLES  = 2,
  parameter int PEND_W      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              src,
  output logic              out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int MAXC =
    (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES
                               : GAP_CYCLES;
  localparam int CW =
    (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int GL =
    (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  localparam logic [CW-1:0] HLOAD =
    CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0] GLOAD = CW'(GL);
  localparam logic [PEND_W-1:0] PMAX = '1;
  localparam logic [PEND_W-1:0] PONE =
    PEND_W'(1);
  localparam logic [CW-1:0] CONE = CW'(1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_n;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_n;
  logic [PEND_W-1:0] pend_n;
  logic              ovf_n;
  logic              done;
  logic              fin;
  logic              take;
  logic              req;

  // take: the phase is over (or nothing runs), so
  // a new pulse may start this edge. A request
  // arriving on that edge starts at once instead
  // of passing through the queue.
  always_comb begin
    done    = (cnt == '0);
    fin     = done &&
              ((state == GAP) ||
               (state == HIGH && GAP_CYCLES == 0));
    take    = fin ||
              (state != HIGH && state != GAP);
    req     = src || (pending != '0);
    state_n = state;
    cnt_n   = cnt;
    pend_n  = pending;
    ovf_n   = 1'b0;
    if (take) begin
      if (!src && pending != '0)
        pend_n = pending - PONE;
      if (req) begin
        state_n = HIGH;
        cnt_n   = HLOAD;
      end else begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    end else begin
      if (src) begin
        if (pending == PMAX)
          ovf_n = 1'b1;
        else
          pend_n = pending + PONE;
      end
      // only HIGH with a nonzero gap lands here
      // with the counter expired
      if (done) begin
        state_n = GAP;
        cnt_n   = GLOAD;
      end else begin
        cnt_n = cnt - CONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      pending  <= '0;
      overflow <= 1'b0;
      out      <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      pending  <= pend_n;
      overflow <= ovf_n;
      out      <= (state_n == HIGH);
    end
  end

  assign busy = (state != IDLE) || (pending != '0);

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: three instances
// (8/2, 20/2, 8/0) checked against a schedule model.
module tb_pulse_stretcher;

  logic       clk;
  logic       reset;
  logic       src [3];
  logic       o   [3];
  logic       b   [3];
  logic [3:0] p   [3];
  logic       ov  [3];

  int compared;
  int mismatched;
  int pulses [3];
  int ovfs   [3];

  pulse_stretcher #(
    .HIGH_CYCLES(8), .GAP_CYCLES(2), .PEND_W(4)
  ) d0 (
    .clk(clk), .reset(reset), .src(src[0]),
    .out(o[0]), .busy(b[0]), .pending(p[0]),
    .overflow(ov[0])
  );

  pulse_stretcher #(
    .HIGH_CYCLES(20), .GAP_CYCLES(2), .PEND_W(4)
  ) d1 (
    .clk(clk), .reset(reset), .src(src[1]),
    .out(o[1]), .busy(b[1]), .pending(p[1]),
    .overflow(ov[1])
  );

  pulse_stretcher #(
    .HIGH_CYCLES(8), .GAP_CYCLES(0), .PEND_W(4)
  ) d2 (
    .clk(clk), .reset(reset), .src(src[2]),
    .out(o[2]), .busy(b[2]), .pending(p[2]),
    .overflow(ov[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d want %0d",
               nm, act, exp);
    end
  endtask

  // Model: every accepted request owns a start
  // edge. A request starts at once if the previous
  // pulse+gap is over, else one period after the
  // latest scheduled start. Everything else follows
  // from the latest start time.
  int     hc [3];
  int     gc [3];
  longint last [3];
  int     e_out [3];
  int     e_busy [3];
  int     e_pend [3];
  int     e_ovf [3];
  logic   sv [3];
  longint cyc;
  longint per;
  longint q;
  longint cand;
  longint sa;
  logic   po [3];

  initial begin
    hc  = '{8, 20, 8};
    gc  = '{2, 2, 0};
    cyc = 0;
    for (int i = 0; i < 3; i++) begin
      last[i]   = -100000;
      pulses[i] = 0;
      ovfs[i]   = 0;
      po[i]     = 1'b0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 3; i++) sv[i] = src[i];
      for (int i = 0; i < 3; i++) begin
        per = longint'(hc[i] + gc[i]);
        if (!reset) begin
          last[i] = -100000;
        end else begin
          q = (last[i] > cyc)
            ? (last[i] - cyc + per - 1) / per : 0;
          e_ovf[i] = 0;
          if (sv[i]) begin
            cand = (last[i] + per > cyc)
                 ? last[i] + per : cyc;
            if (cand == cyc)
              last[i] = cyc;
            else if (q >= 15)
              e_ovf[i] = 1;
            else
              last[i] = cand;
          end
        end
        q = (last[i] > cyc)
          ? (last[i] - cyc + per - 1) / per : 0;
        sa = last[i] - q * per;
        e_pend[i] = int'(q);
        e_out[i]  = (cyc >= sa &&
                     cyc - sa < hc[i]) ? 1 : 0;
        e_busy[i] = (cyc < last[i] + per) ? 1 : 0;
      end
      #1;
      if (reset) begin
        for (int i = 0; i < 3; i++) begin
          chk($sformatf("out%0d@%0d", i, cyc),
              int'(o[i]), e_out[i]);
          chk($sformatf("busy%0d@%0d", i, cyc),
              int'(b[i]), e_busy[i]);
          chk($sformatf("pend%0d@%0d", i, cyc),
              int'(p[i]), e_pend[i]);
          chk($sformatf("ovf%0d@%0d", i, cyc),
              int'(ov[i]), e_ovf[i]);
          if (o[i] && !po[i]) pulses[i]++;
          if (ov[i]) ovfs[i]++;
          po[i] = o[i];
        end
      end else begin
        for (int i = 0; i < 3; i++) po[i] = 1'b0;
      end
    end
  end

  task automatic wait_idle(string nm);
    int any;
    any = 1;
    for (int n = 0; n < 600; n++) begin
      any = int'(b[0] | b[1] | b[2]);
      if (any == 0) break;
      @(negedge clk);
    end
    chk(nm, any, 0);
  endtask

  int pc;
  int oc;

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b0;
    for (int i = 0; i < 3; i++) src[i] = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out", int'(o[0]), 0);
    chk("rst_busy", int'(b[0]), 0);
    chk("rst_pend", int'(p[0]), 0);
    chk("rst_ovf", int'(ov[0]), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // single pulse: high 8, idle after 10
    src[0] = 1'b1;
    @(negedge clk);
    src[0] = 1'b0;
    chk("single_k", int'(o[0]), 1);
    repeat (7) @(negedge clk);
    chk("single_k7", int'(o[0]), 1);
    @(negedge clk);
    chk("single_k8", int'(o[0]), 0);
    chk("single_busy8", int'(b[0]), 1);
    @(negedge clk);
    chk("single_busy9", int'(b[0]), 1);
    @(negedge clk);
    chk("single_busy10", int'(b[0]), 0);
    wait_idle("idle_a");

    // three back-to-back requests
    pc = pulses[0];
    src[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("three_p1", int'(p[0]), 1);
    @(negedge clk);
    src[0] = 1'b0;
    chk("three_p2", int'(p[0]), 2);
    wait_idle("idle_b");
    chk("three_pulses", pulses[0] - pc, 3);

    // request one edge before gap end
    src[0] = 1'b1;
    @(negedge clk);
    src[0] = 1'b0;
    repeat (8) @(negedge clk);
    src[0] = 1'b1;
    @(negedge clk);
    src[0] = 1'b0;
    chk("gapreq_p", int'(p[0]), 1);
    chk("gapreq_out9", int'(o[0]), 0);
    @(negedge clk);
    chk("gapreq_p10", int'(p[0]), 0);
    chk("gapreq_out10", int'(o[0]), 1);
    wait_idle("idle_c");

    // request on the gap-end edge itself
    src[0] = 1'b1;
    @(negedge clk);
    src[0] = 1'b0;
    repeat (9) @(negedge clk);
    src[0] = 1'b1;
    @(negedge clk);
    src[0] = 1'b0;
    chk("gapend_p", int'(p[0]), 0);
    chk("gapend_out", int'(o[0]), 1);
    wait_idle("idle_d");

    // 17 requests into one long pulse
    pc = pulses[1];
    oc = ovfs[1];
    src[1] = 1'b1;
    repeat (16) @(negedge clk);
    chk("sat_p15", int'(p[1]), 15);
    @(negedge clk);
    src[1] = 1'b0;
    chk("sat_hold", int'(p[1]), 15);
    chk("sat_ovf", int'(ov[1]), 1);
    @(negedge clk);
    chk("sat_ovf_clr", int'(ov[1]), 0);
    wait_idle("idle_e");
    chk("sat_ovf_cnt", ovfs[1] - oc, 1);
    chk("sat_pulses", pulses[1] - pc, 16);

    // async reset mid-HIGH with 3 queued
    src[0] = 1'b1;
    repeat (4) @(negedge clk);
    src[0] = 1'b0;
    chk("ar_p3", int'(p[0]), 3);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_out", int'(o[0]), 0);
    chk("ar_pend", int'(p[0]), 0);
    chk("ar_busy", int'(b[0]), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("ar_after_out", int'(o[0]), 0);
    chk("ar_after_busy", int'(b[0]), 0);

    // zero gap: two requests merge
    pc = pulses[2];
    src[2] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    src[2] = 1'b0;
    repeat (14) @(negedge clk);
    chk("nogap_k15", int'(o[2]), 1);
    @(negedge clk);
    chk("nogap_k16", int'(o[2]), 0);
    chk("nogap_busy", int'(b[2]), 0);
    chk("nogap_pulses", pulses[2] - pc, 1);
    wait_idle("idle_f");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
